shadow_weight_writer: RTL and testbench

//  A-SPSA-side master for the double-buffered shadow weight memory. Accepts one bank of

---
 rtl/shadow_weight_writer.sv | 187 ++++++++++++++++++
 tb/tb_shadow_weight_writer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_weight_writer.sv
// Streams one bank of weights into the inactive shadow buffer, then runs the 4-phase swap handshake.
// Optional macro SWAP_TIMEOUT_EN bounds each handshake phase to TIMEOUT_CYCLES cycles.
module shadow_weight_writer #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned NUM_WEIGHTS    = 1170,
    parameter int unsigned NUM_BANKS      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_wr,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            start_bank,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_data,
    output logic                  upd_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic [1:0]            wr_bank_sel,
    output logic                  swap_req,
    input  logic                  swap_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StReq   = 2'd2;
    localparam logic [1:0] StRel   = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    // The beat counter never wraps inside a bank, so one bank must fit the address space.
    if (NUM_WEIGHTS == 0 || 64'(NUM_WEIGHTS) > (64'd1 << ADDR_WIDTH) || TIMEOUT_CYCLES == 0)
    begin : g_bad_cfg
        $error("shadow_weight_writer: invalid parameter combination");
    end

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            bank_q, bank_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]            wr_bank_sel_q, wr_bank_sel_d;
    logic                  swap_req_q, swap_req_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  beat;
    logic                  start_ok;

`ifdef SWAP_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            timeout;
    assign timeout = (tmr_q == TmrW'(TIMEOUT_CYCLES));
`endif

    assign upd_ready = (state_q == StWrite);
    assign busy      = (state_q != StIdle);
    assign beat      = upd_valid && upd_ready;
    // A still-high ack means the previous handshake has not released yet.
    assign start_ok  = (32'(start_bank) < NUM_BANKS) && !swap_ack;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bank_d        = bank_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_bank_sel_d = wr_bank_sel_q;
        swap_req_d    = swap_req_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
`ifdef SWAP_TIMEOUT_EN
        tmr_d         = tmr_q;
`endif
        case (state_q)
            StIdle: begin
                swap_req_d = 1'b0;
                if (start) begin
                    if (start_ok) begin
                        bank_d  = start_bank;
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                if (beat) begin
                    wr_en_d       = 1'b1;
                    wr_addr_d     = cnt_q;
                    wr_data_d     = upd_data;
                    wr_bank_sel_d = bank_q;
                    cnt_d         = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LastAddr) begin
                        state_d = StReq;
`ifdef SWAP_TIMEOUT_EN
                        tmr_d   = '0;
`endif
                    end
                end
            end
            StReq: begin
                // Only honour an ack that answers a request actually on the wire.
                if (swap_req_q && swap_ack) begin
                    swap_req_d = 1'b0;
                    state_d    = StRel;
`ifdef SWAP_TIMEOUT_EN
                    tmr_d      = '0;
                end else if (timeout) begin
                    swap_req_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = StIdle;
                end else begin
                    swap_req_d = 1'b1;
                    tmr_d      = tmr_q + TmrW'(1);
`else
                end else begin
                    swap_req_d = 1'b1;
`endif
                end
            end
            StRel: begin
                swap_req_d = 1'b0;
                if (!swap_ack) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
`ifdef SWAP_TIMEOUT_EN
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_wr) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bank_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_bank_sel_q <= '0;
            swap_req_q    <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef SWAP_TIMEOUT_EN
            tmr_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bank_q        <= bank_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_bank_sel_q <= wr_bank_sel_d;
            swap_req_q    <= swap_req_d;
            done_q        <= done_d;
            err_q         <= err_d;
`ifdef SWAP_TIMEOUT_EN
            tmr_q         <= tmr_d;
`endif
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_bank_sel = wr_bank_sel_q;
    assign swap_req    = swap_req_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_shadow_weight_writer.sv
// Directed bench for shadow_weight_writer with a 4-word bank and a 16-cycle handshake limit.
// The timeout scenario is exercised only when SWAP_TIMEOUT_EN is defined.
module tb_shadow_weight_writer;

    logic        clk_wr = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  start_bank;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic [1:0]  wr_bank_sel;
    logic        swap_req;
    logic        swap_ack;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk_wr = ~clk_wr;

    shadow_weight_writer #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (16),
        .NUM_WEIGHTS   (4),
        .NUM_BANKS     (3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_wr     (clk_wr),
        .rst        (rst),
        .start      (start),
        .start_bank (start_bank),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_bank_sel(wr_bank_sel),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".swap_req"}, 32'(swap_req), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".upd_ready"}, 32'(upd_ready), 0);
        chk({tag, ".done"}, 32'(done), 0);
    endtask

    initial begin
        int cnt;
        logic done_seen;

        rst = 1'b1; start = 1'b0; start_bank = 2'd0;
        upd_valid = 1'b0; upd_data = 16'h0; swap_ack = 1'b0;
        step();
        step();
        chk_idle_outputs("reset");
        chk("reset.err", 32'(err), 0);
        chk("reset.wr_addr", 32'(wr_addr), 0);
        chk("reset.wr_data", 32'(wr_data), 0);
        chk("reset.bank_sel", 32'(wr_bank_sel), 0);
        rst = 1'b0;
        step();

        // Back-to-back burst into bank 1, then the full handshake.
        start = 1'b1; start_bank = 2'd1;
        step();
        start = 1'b0;
        chk("t1.busy", 32'(busy), 1);
        chk("t1.upd_ready", 32'(upd_ready), 1);
        chk("t1.wr_en_pre", 32'(wr_en), 0);
        upd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            upd_data = 16'h1111 * 16'(i + 1);
            step();
            chk("t1.wr_en", 32'(wr_en), 1);
            chk("t1.wr_addr", 32'(wr_addr), i);
            chk("t1.wr_data", 32'(wr_data), 32'h1111 * (i + 1));
            chk("t1.bank_sel", 32'(wr_bank_sel), 1);
            chk("t1.swap_req_low", 32'(swap_req), 0);
            chk("t1.upd_ready", 32'(upd_ready), (i < 3) ? 1 : 0);
        end
        upd_valid = 1'b0;
        step();
        chk("t1.wr_en_after", 32'(wr_en), 0);
        chk("t1.swap_req_rise", 32'(swap_req), 1);
        chk("t1.wr_addr_hold", 32'(wr_addr), 3);

        // Ack arrives late; req must hold until then.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3.swap_req_hold", 32'(swap_req), 1);
        end
        swap_ack = 1'b1;
        step();
        chk("t3.swap_req_fall", 32'(swap_req), 0);
        chk("t3.busy_rel", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3.done_wait", 32'(done), 0);
            chk("t3.swap_req_rel", 32'(swap_req), 0);
            chk("t3.busy_wait", 32'(busy), 1);
        end
        swap_ack = 1'b0;
        step();
        chk("t3.done", 32'(done), 1);
        chk("t3.busy_end", 32'(busy), 0);
        step();
        chk("t3.done_pulse", 32'(done), 0);

        // Gapped burst into bank 2 with a stray start during the gap.
        start = 1'b1; start_bank = 2'd2;
        step();
        start = 1'b0;
        upd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            upd_data = 16'h1111 * 16'(i + 1);
            step();
            chk("t2.wr_addr", 32'(wr_addr), i);
            chk("t2.wr_en", 32'(wr_en), 1);
        end
        upd_valid = 1'b0; upd_data = 16'hdead;
        start = 1'b1; start_bank = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            start = 1'b0;
            chk("t2.gap_wr_en", 32'(wr_en), 0);
            chk("t2.gap_addr", 32'(wr_addr), 2);
            chk("t2.gap_data", 32'(wr_data), 32'h3333);
            chk("t2.gap_err", 32'(err), 0);
        end
        upd_valid = 1'b1; upd_data = 16'h4444;
        step();
        upd_valid = 1'b0;
        chk("t2.last_addr", 32'(wr_addr), 3);
        chk("t2.last_data", 32'(wr_data), 32'h4444);
        chk("t5.bank_kept", 32'(wr_bank_sel), 2);
        step();
        chk("t2.no_dup", 32'(wr_en), 0);
        chk("t2.swap_req", 32'(swap_req), 1);
        swap_ack = 1'b1;
        step();
        chk("t2.swap_req_fall", 32'(swap_req), 0);
        swap_ack = 1'b0;
        step();
        chk("t2.done", 32'(done), 1);

        // Rejected starts: bad bank, then ack still high.
        start = 1'b1; start_bank = 2'd3;
        step();
        start = 1'b0;
        chk("t4.err_bank", 32'(err), 1);
        chk_idle_outputs("t4.bank");
        step();
        chk("t4.err_pulse", 32'(err), 0);
        chk("t4.busy_stay", 32'(busy), 0);
        swap_ack = 1'b1; start = 1'b1; start_bank = 2'd0;
        step();
        start = 1'b0;
        chk("t4.err_ack", 32'(err), 1);
        chk_idle_outputs("t4.ack");
        swap_ack = 1'b0;
        step();
        chk("t4.err_ack_pulse", 32'(err), 0);

        // Reset in the middle of a bank, then a fresh start from address 0.
        start = 1'b1; start_bank = 2'd1;
        step();
        start = 1'b0; upd_valid = 1'b1; upd_data = 16'haaaa;
        step();
        upd_data = 16'hbbbb;
        step();
        chk("t5.pre_rst_addr", 32'(wr_addr), 1);
        rst = 1'b1; upd_valid = 1'b0;
        step();
        chk_idle_outputs("t5.rst");
        chk("t5.rst_addr", 32'(wr_addr), 0);
        chk("t5.rst_data", 32'(wr_data), 0);
        chk("t5.rst_bank", 32'(wr_bank_sel), 0);
        rst = 1'b0;
        start = 1'b1; start_bank = 2'd2;
        step();
        start = 1'b0; upd_valid = 1'b1; upd_data = 16'hcccc;
        step();
        chk("t5.restart_addr", 32'(wr_addr), 0);
        chk("t5.restart_data", 32'(wr_data), 32'hcccc);
        chk("t5.restart_bank", 32'(wr_bank_sel), 2);
        for (int i = 0; i < 3; i++) step();
        upd_valid = 1'b0;
        step();
        chk("t6.swap_req_rise", 32'(swap_req), 1);

        // Ack never comes.
        cnt = 1;
        done_seen = 1'b0;
`ifdef SWAP_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) done_seen = 1'b1;
            if (!swap_req) break;
            cnt++;
        end
        chk("t6.req_cycles", 32'(cnt), 16);
        chk("t6.err", 32'(err), 1);
        chk("t6.busy", 32'(busy), 0);
        chk("t6.no_done", 32'(done_seen), 0);
        step();
        chk("t6.err_pulse", 32'(err), 0);
`else
        for (int i = 0; i < 30; i++) begin
            step();
            if (done || err) done_seen = 1'b1;
            if (swap_req) cnt++;
        end
        chk("t6.req_held", 32'(cnt), 31);
        chk("t6.no_done_err", 32'(done_seen), 0);
        chk("t6.busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        chk("t6.rst_req", 32'(swap_req), 0);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
